game_flow_ctrl: RTL and testbench
=================================

# game_flow_ctrl

Top-level game sequencer for the Mario datapath. It drives the `game_state` code consumed by the player-motion state machine and by rendering. It owns lives, the level countdown timer and the score. It watches the player's vertical position, page index and brick-hit flags to detect death, level completion and score events. All logic runs on the frame clock, so one cycle equals one video frame.

## Interface
Parameters:
- `FRAME_HZ`, 60: frames per timer second.
- `TIME_LIMIT`, 300: level time in seconds (9-bit).
- `LIVES_INIT`, 3: lives at game start (max 7).
- `DEATH_Y`, 400: player Y at or beyond which the player is dead (fell into a pit).
- `GOAL_PAGE`, 3: page index that completes the level.
- `DIE_FRAMES`, 60: length of the death freeze.
- `RESTART_FRAMES`, 2: length of the restart pulse.

Ports:
- `frame_clk`, in, 1: frame clock, the only clock.
- `reset`, in, 1: asynchronous, active-low.
- `keycode`, in, 8: current USB keycode.
- `ball_y`, in, 10: player Y position.
- `page_index`, in, 32: signed page of the player.
- `blockflags`, in, 8: per-brick hit flags from the motion block.
- `game_state`, out, 2: 00 TITLE, 01 PLAY, 10 RESTART, 11 FROZEN.
- `lives`, out, 3: remaining lives.
- `time_left`, out, 9: seconds remaining.
- `score`, out, 14: score, 0..9999.
- `game_over`, out, 1: high in OVER.
- `level_won`, out, 1: high in WIN.

## Operation
- FSM states and their `game_state` codes:
  - S_TITLE → 00.
  - S_PLAY → 01.
  - S_RESTART → 10.
  - S_DYING, S_OVER, S_WIN, S_PAUSE → 11.
- Start key is Enter, 8'h28. A press is the frame where `keycode` equals 8'h28 and it did not equal 8'h28 on the previous frame. Holding the key produces one press.
- S_TITLE: on a start press, go to S_RESTART. `lives`, `time_left` and `score` reload to LIVES_INIT, TIME_LIMIT and 0.
- S_RESTART:
  - Holds for exactly RESTART_FRAMES frames, then goes to S_PLAY.
  - `time_left` reloads to TIME_LIMIT and the frame divider clears on entry.
- S_PLAY transition priority:
  1. Win: `page_index >= GOAL_PAGE` → S_WIN.
  2. Death: `ball_y >= DEATH_Y` OR `time_left == 0` → S_DYING.
  - A death by fall and a death by timeout in the same frame cost one life only.
- Timer:
  - In S_PLAY only, the divider counts 0..FRAME_HZ-1.
  - When the divider wraps, `time_left` decrements, saturating at 0.
- S_DYING:
  - Holds for DIE_FRAMES frames. `lives` decrements on the exit frame.
  - If `lives` was 1 on the exit frame → S_OVER with `lives` = 0. Otherwise → S_RESTART.
- S_OVER and S_WIN: a start press → S_TITLE.
- Score:
  - In S_PLAY only, let rise = `blockflags & ~blockflags_q`, where `blockflags_q` is the previous frame's flags.
  - Add 10 × popcount(rise) each frame, saturating at 9999.
  - Falling flags (the page-change clear) add nothing.
  - `blockflags_q` updates every frame in every state, so flags already set on PLAY entry score nothing.

## Timing
- All outputs are registered and change one frame after the causing input frame.
- Reset (`reset` low) forces, asynchronously:
  - state S_TITLE, `game_state` 00;
  - `lives` LIVES_INIT, `time_left` TIME_LIMIT, `score` 0;
  - `game_over` 0, `level_won` 0;
  - divider, hold counter, key history and `blockflags_q` all 0.
- Reset asserted mid-DYING or mid-RESTART aborts the hold. There is no pending life decrement.
- The start-press edge detection adds one register stage. A press is acted on in the same frame it is detected.
- The RESTART pulse is at least 1 frame even if RESTART_FRAMES = 0, which the motion block needs to recentre.
- The hold counter is wide enough for max(DIE_FRAMES, RESTART_FRAMES). It loads on state entry and the state exits when the counter reaches 1.

## Configuration
- `GAME_FLOW_PAUSE_EN` defined:
  - A press of 'P' (8'h13, same edge rule as Enter) in S_PLAY enters S_PAUSE. A second press returns to S_PLAY.
  - In S_PAUSE the divider and `time_left` are frozen, score is not accumulated, and death and win are not evaluated.
  - The divider value is kept across the pause.
- Not defined: S_PAUSE and its logic are absent and 8'h13 is ignored.

## Structure
- Package `game_pkg` holds:
  - the state enum;
  - the `game_state` encodings (GS_TITLE, GS_PLAY, GS_RESTART, GS_FROZEN);
  - the key constants KEY_ENTER = 8'h28 and KEY_P = 8'h13;
  - SCORE_PER_BRICK = 10 and SCORE_MAX = 9999.
- Sub-module `key_press_det`, parameterized by key code, produces the single-frame press pulse. It is instanced once for Enter and once for P when pause is compiled in.

## Test plan
- Reset low, then release with no keys: `game_state` = 00, `lives` = 3, `time_left` = 300, `score` = 0. Hold Enter 5 frames: exactly 2 frames of 10, then 01.
- PLAY for 120 frames: `time_left` = 298. Set `blockflags` 0→8'b00000101: `score` +20 one frame later. Clear flags, then set bit 0 again: +10.
- PLAY with `ball_y` = 400: 60 frames of 11, then `lives` = 2 and `game_state` 10. Repeat until the last life is lost: `game_over` = 1 and `lives` = 0. Enter press → 00.
- Same frame `page_index` = 3 and `ball_y` = 420: S_WIN, `level_won` = 1, lives unchanged.
- `time_left` reaches 0 while `ball_y` ≥ DEATH_Y in the same frame: exactly one life lost. Reset pulsed mid-DYING: state 00, `lives` = 3.
- With GAME_FLOW_PAUSE_EN, press P for 200 frames: `time_left` unchanged and `game_state` 11. A second P → 01. Without the macro, P has no effect.

Source files
------------

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game flow sequencer:
//   - state_t       : sequencer states (S_PAUSE only with GAME_FLOW_PAUSE_EN)
//   - GS_*          : 2-bit game_state codes seen by motion and rendering
//   - KEY_ENTER/P   : USB keycodes for start and pause
//   - SCORE_*       : points per brick and the score ceiling
//   - popcount8     : counts set bits in a byte of brick flags
//   - encodeState   : maps a sequencer state onto its game_state code
// Optional feature macro: GAME_FLOW_PAUSE_EN
// ---------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [2:0] {
        S_TITLE   = 3'd0,
        S_PLAY    = 3'd1,
        S_RESTART = 3'd2,
        S_DYING   = 3'd3,
        S_OVER    = 3'd4,
        S_WIN     = 3'd5
`ifdef GAME_FLOW_PAUSE_EN
        ,
        S_PAUSE   = 3'd6
`endif
    } state_t;

    localparam logic [1:0] GS_TITLE   = 2'b00;
    localparam logic [1:0] GS_PLAY    = 2'b01;
    localparam logic [1:0] GS_RESTART = 2'b10;
    localparam logic [1:0] GS_FROZEN  = 2'b11;

    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_P     = 8'h13;

    localparam int SCORE_PER_BRICK = 10;
    localparam int SCORE_MAX       = 9999;

    // Number of bricks that were hit this frame, at most eight.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Every non-running state looks "frozen" to the motion block.
    function automatic logic [1:0] encodeState(input state_t s);
        logic [1:0] gs;
        case (s)
            S_TITLE:   gs = GS_TITLE;
            S_PLAY:    gs = GS_PLAY;
            S_RESTART: gs = GS_RESTART;
            default:   gs = GS_FROZEN;
        endcase
        return gs;
    endfunction

endpackage

// File: rtl/key_press_det.sv
// ---------------------------------------------------------------------------
// key_press_det
// Turns a level keycode into a single-frame press pulse for one key. Holding
// the key produces one pulse; the pulse is combinational from the current
// keycode so the press is usable in the frame it is seen.
// Ports:
//   i_clk      frame clock
//   i_resetN   asynchronous active-low reset (clears key history)
//   i_keycode  current USB keycode
//   o_press    high for the first frame the key is down
// ---------------------------------------------------------------------------
module key_press_det
    import game_pkg::*;
#(
    parameter logic [7:0] KEY_CODE = KEY_ENTER
) (
    input  logic       i_clk,
    input  logic       i_resetN,
    input  logic [7:0] i_keycode,
    output logic       o_press
);

    logic w_keyDown;
    logic r_keyWasDown;

    assign w_keyDown = (i_keycode == KEY_CODE);

    // Remember whether the key was down last frame so a held key is seen
    // as a single press.
    always_ff @(posedge i_clk or negedge i_resetN) begin
        if (!i_resetN) begin
            r_keyWasDown <= 1'b0;
        end else begin
            r_keyWasDown <= w_keyDown;
        end
    end

    assign o_press = w_keyDown && !r_keyWasDown;

endmodule

// File: rtl/game_flow_ctrl.sv
// ---------------------------------------------------------------------------
// game_flow_ctrl
// Top-level game sequencer. Owns lives, the level countdown and the score,
// and publishes game_state to the motion and rendering blocks. One clock
// cycle is one video frame.
// Ports:
//   frame_clk   frame clock (only clock)
//   reset       asynchronous active-low reset
//   keycode     current USB keycode (Enter starts, P pauses when enabled)
//   ball_y      player Y; at or below DEATH_Y the player has fallen
//   page_index  signed page of the player; GOAL_PAGE or more wins
//   blockflags  per-brick hit flags; rising bits score in PLAY
//   game_state  00 TITLE, 01 PLAY, 10 RESTART, 11 FROZEN
//   lives       remaining lives
//   time_left   level seconds remaining
//   score       0..9999
//   game_over   high while in OVER
//   level_won   high while in WIN
// Optional feature macro: GAME_FLOW_PAUSE_EN (P toggles a pause in PLAY)
// ---------------------------------------------------------------------------
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int FRAME_HZ       = 60,
    parameter int TIME_LIMIT     = 300,
    parameter int LIVES_INIT     = 3,
    parameter int DEATH_Y        = 400,
    parameter int GOAL_PAGE      = 3,
    parameter int DIE_FRAMES     = 60,
    parameter int RESTART_FRAMES = 2
) (
    input  logic        frame_clk,
    input  logic        reset,
    input  logic [7:0]  keycode,
    input  logic [9:0]  ball_y,
    input  logic [31:0] page_index,
    input  logic [7:0]  blockflags,
    output logic [1:0]  game_state,
    output logic [2:0]  lives,
    output logic [8:0]  time_left,
    output logic [13:0] score,
    output logic        game_over,
    output logic        level_won
);

    localparam int DIE_LOAD     = (DIE_FRAMES < 1) ? 1 : DIE_FRAMES;
    localparam int RESTART_LOAD = (RESTART_FRAMES < 1) ? 1 : RESTART_FRAMES;
    localparam int HOLD_MAX     = (DIE_LOAD > RESTART_LOAD) ? DIE_LOAD : RESTART_LOAD;
    localparam int HOLD_W       = $clog2(HOLD_MAX + 1);
    localparam int DIV_W        = (FRAME_HZ > 1) ? $clog2(FRAME_HZ) : 1;

    localparam logic [9:0]         DEATH_Y_V = 10'(DEATH_Y);
    localparam logic signed [31:0] GOAL_V    = 32'(GOAL_PAGE);
    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(FRAME_HZ - 1);

    state_t              r_state;
    state_t              w_nextState;
    logic [HOLD_W-1:0]   r_hold;
    logic [DIV_W-1:0]    r_div;
    logic [2:0]          r_lives;
    logic [8:0]          r_timeLeft;
    logic [13:0]         r_score;
    logic [7:0]          r_flagsQ;
    logic [1:0]          r_gameState;
    logic                r_gameOver;
    logic                r_levelWon;

    logic                w_startPress;
    logic                w_holdDone;
    logic                w_fell;
    logic                w_atGoal;
    logic                w_enterRestart;
    logic                w_enterDying;
    logic [7:0]          w_rise;
    logic [14:0]         w_scoreGain;
    logic [14:0]         w_scoreSum;
    logic [13:0]         w_scoreNext;

    key_press_det #(.KEY_CODE(KEY_ENTER)) u_enterDet (
        .i_clk     (frame_clk),
        .i_resetN  (reset),
        .i_keycode (keycode),
        .o_press   (w_startPress)
    );

`ifdef GAME_FLOW_PAUSE_EN
    logic w_pausePress;

    key_press_det #(.KEY_CODE(KEY_P)) u_pauseDet (
        .i_clk     (frame_clk),
        .i_resetN  (reset),
        .i_keycode (keycode),
        .o_press   (w_pausePress)
    );
`endif

    assign w_holdDone     = (r_hold == HOLD_W'(1));
    assign w_fell         = (ball_y >= DEATH_Y_V);
    assign w_atGoal       = ($signed(page_index) >= GOAL_V);
    assign w_enterRestart = (w_nextState == S_RESTART) && (r_state != S_RESTART);
    assign w_enterDying   = (w_nextState == S_DYING) && (r_state != S_DYING);

    // Only bricks that turn on this frame score; the page-change clear drops
    // flags, which never counts.
    assign w_rise      = blockflags & ~r_flagsQ;
    assign w_scoreGain = 15'(popcount8(w_rise)) * 15'(SCORE_PER_BRICK);
    assign w_scoreSum  = {1'b0, r_score} + w_scoreGain;
    assign w_scoreNext = (w_scoreSum > 15'(SCORE_MAX)) ? 14'(SCORE_MAX) : w_scoreSum[13:0];

    // Next-state decision. In PLAY a win beats a death, and a fall plus a
    // timeout in the same frame is still a single death.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_TITLE: begin
                if (w_startPress) begin
                    w_nextState = S_RESTART;
                end
            end
            S_RESTART: begin
                if (w_holdDone) begin
                    w_nextState = S_PLAY;
                end
            end
            S_PLAY: begin
                if (w_atGoal) begin
                    w_nextState = S_WIN;
                end else if (w_fell || (r_timeLeft == 9'd0)) begin
                    w_nextState = S_DYING;
                end
`ifdef GAME_FLOW_PAUSE_EN
                else if (w_pausePress) begin
                    w_nextState = S_PAUSE;
                end
`endif
            end
            S_DYING: begin
                if (w_holdDone) begin
                    w_nextState = (r_lives <= 3'd1) ? S_OVER : S_RESTART;
                end
            end
            S_OVER, S_WIN: begin
                if (w_startPress) begin
                    w_nextState = S_TITLE;
                end
            end
`ifdef GAME_FLOW_PAUSE_EN
            S_PAUSE: begin
                if (w_pausePress) begin
                    w_nextState = S_PLAY;
                end
            end
`endif
            default: begin
                w_nextState = S_TITLE;
            end
        endcase
    end

    // State register plus the shared hold counter. The counter loads on entry
    // to DYING or RESTART and the state leaves when it reads 1, so a load of N
    // keeps the state for exactly N frames.
    always_ff @(posedge frame_clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_TITLE;
            r_hold  <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_enterDying) begin
                r_hold <= HOLD_W'(DIE_LOAD);
            end else if (w_enterRestart) begin
                r_hold <= HOLD_W'(RESTART_LOAD);
            end else if (r_hold != '0) begin
                r_hold <= r_hold - HOLD_W'(1);
            end
        end
    end

    // Level timer. Every restart gives a fresh level time and a clean divider;
    // otherwise it only runs while actually playing, so a pause keeps the
    // divider phase intact.
    always_ff @(posedge frame_clk or negedge reset) begin
        if (!reset) begin
            r_div      <= '0;
            r_timeLeft <= 9'(TIME_LIMIT);
        end else if (w_enterRestart) begin
            r_div      <= '0;
            r_timeLeft <= 9'(TIME_LIMIT);
        end else if (r_state == S_PLAY) begin
            if (r_div == DIV_LAST) begin
                r_div <= '0;
                if (r_timeLeft != 9'd0) begin
                    r_timeLeft <= r_timeLeft - 9'd1;
                end
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    // Lives reload when a new game starts and drop by one as the death
    // freeze ends, never going below zero.
    always_ff @(posedge frame_clk or negedge reset) begin
        if (!reset) begin
            r_lives <= 3'(LIVES_INIT);
        end else if ((r_state == S_TITLE) && w_startPress) begin
            r_lives <= 3'(LIVES_INIT);
        end else if ((r_state == S_DYING) && w_holdDone) begin
            r_lives <= (r_lives > 3'd1) ? (r_lives - 3'd1) : 3'd0;
        end
    end

    // Score accumulates only while playing, but the flag history is kept in
    // every state so bricks already lit on entry to PLAY are not rewarded.
    always_ff @(posedge frame_clk or negedge reset) begin
        if (!reset) begin
            r_score  <= '0;
            r_flagsQ <= '0;
        end else begin
            r_flagsQ <= blockflags;
            if ((r_state == S_TITLE) && w_startPress) begin
                r_score <= '0;
            end else if (r_state == S_PLAY) begin
                r_score <= w_scoreNext;
            end
        end
    end

    // Registered status outputs, computed from the state being entered so
    // they line up with the state register.
    always_ff @(posedge frame_clk or negedge reset) begin
        if (!reset) begin
            r_gameState <= GS_TITLE;
            r_gameOver  <= 1'b0;
            r_levelWon  <= 1'b0;
        end else begin
            r_gameState <= encodeState(w_nextState);
            r_gameOver  <= (w_nextState == S_OVER);
            r_levelWon  <= (w_nextState == S_WIN);
        end
    end

    assign game_state = r_gameState;
    assign lives      = r_lives;
    assign time_left  = r_timeLeft;
    assign score      = r_score;
    assign game_over  = r_gameOver;
    assign level_won  = r_levelWon;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_flow_ctrl
// Self-checking bench for game_flow_ctrl with default parameters. A
// frame-level behavioural model (mode names, frames-remaining countdowns,
// plain integer arithmetic) predicts every output after each frame.
// Optional feature macro: GAME_FLOW_PAUSE_EN (bench follows the same build)
// ---------------------------------------------------------------------------
module tb_game_flow_ctrl;

    localparam int M_LIVES   = 3;
    localparam int M_TIME    = 300;
    localparam int M_HZ      = 60;
    localparam int M_DIE     = 60;
    localparam int M_RESTART = 2;
`ifdef GAME_FLOW_PAUSE_EN
    localparam bit PAUSE_BUILD = 1'b1;
`else
    localparam bit PAUSE_BUILD = 1'b0;
`endif

    logic        frame_clk;
    logic        reset;
    logic [7:0]  keycode;
    logic [9:0]  ball_y;
    logic [31:0] page_index;
    logic [7:0]  blockflags;
    logic [1:0]  game_state;
    logic [2:0]  lives;
    logic [8:0]  time_left;
    logic [13:0] score;
    logic        game_over;
    logic        level_won;

    int nChecks = 0;
    int nFails  = 0;

    string      mMode;
    int         mLives;
    int         mTime;
    int         mScore;
    int         mTicks;
    int         mRemain;
    logic [7:0] mPrevKey;
    logic [7:0] mPrevFlags;

    game_flow_ctrl dut (
        .frame_clk  (frame_clk),
        .reset      (reset),
        .keycode    (keycode),
        .ball_y     (ball_y),
        .page_index (page_index),
        .blockflags (blockflags),
        .game_state (game_state),
        .lives      (lives),
        .time_left  (time_left),
        .score      (score),
        .game_over  (game_over),
        .level_won  (level_won)
    );

    // One frame every 10 time units.
    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    // Hard stop in case the run wedges somewhere unexpected.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int gsOf(input string m);
        if (m == "title")   return 0;
        if (m == "play")    return 1;
        if (m == "restart") return 2;
        return 3;
    endfunction

    task automatic modelReset();
        mMode      = "title";
        mLives     = M_LIVES;
        mTime      = M_TIME;
        mScore     = 0;
        mTicks     = 0;
        mRemain    = 0;
        mPrevKey   = 8'h00;
        mPrevFlags = 8'h00;
    endtask

    // Game rules applied to one frame of inputs; leaves the model holding
    // what the outputs should show after that frame's clock edge.
    task automatic modelFrame(input logic [7:0] key, input int y, input int page,
                              input logic [7:0] flags);
        bit    startHit;
        bit    pauseHit;
        int    gain;
        string nxt;
        startHit = (key == 8'h28) && (mPrevKey != 8'h28);
        pauseHit = (key == 8'h13) && (mPrevKey != 8'h13);
        gain     = 10 * $countones(flags & ~mPrevFlags);
        nxt      = mMode;
        if (mMode == "title") begin
            if (startHit) begin
                mLives = M_LIVES;
                mScore = 0;
                nxt    = "restart";
            end
        end else if (mMode == "restart") begin
            mRemain--;
            if (mRemain <= 0) nxt = "play";
        end else if (mMode == "play") begin
            if (page >= 3) nxt = "win";
            else if (y >= 400 || mTime == 0) nxt = "dying";
            else if (PAUSE_BUILD && pauseHit) nxt = "pause";
            mScore = (mScore + gain > 9999) ? 9999 : mScore + gain;
            mTicks++;
            if (mTicks == M_HZ) begin
                mTicks = 0;
                if (mTime > 0) mTime--;
            end
        end else if (mMode == "dying") begin
            mRemain--;
            if (mRemain <= 0) begin
                if (mLives <= 1) begin
                    mLives = 0;
                    nxt    = "over";
                end else begin
                    mLives--;
                    nxt = "restart";
                end
            end
        end else if (mMode == "over" || mMode == "win") begin
            if (startHit) nxt = "title";
        end else if (mMode == "pause") begin
            if (pauseHit) nxt = "play";
        end
        if (nxt == "dying" && mMode != "dying") mRemain = M_DIE;
        if (nxt == "restart" && mMode != "restart") begin
            mRemain = M_RESTART;
            mTime   = M_TIME;
            mTicks  = 0;
        end
        mMode      = nxt;
        mPrevKey   = key;
        mPrevFlags = flags;
    endtask

    task automatic compareAll();
        checkOutput("game_state", int'(game_state), gsOf(mMode));
        checkOutput("lives", int'(lives), mLives);
        checkOutput("time_left", int'(time_left), mTime);
        checkOutput("score", int'(score), mScore);
        checkOutput("game_over", int'(game_over), (mMode == "over") ? 1 : 0);
        checkOutput("level_won", int'(level_won), (mMode == "win") ? 1 : 0);
    endtask

    // Drives one frame (called #1 after a rising edge), advances the model,
    // then samples the outputs #1 after the next rising edge.
    task automatic applyStimulus(input logic [7:0] key, input int y, input int page,
                                 input logic [7:0] flags);
        keycode    = key;
        ball_y     = 10'(y);
        page_index = 32'(page);
        blockflags = flags;
        modelFrame(key, y, page, flags);
        @(posedge frame_clk);
        #1;
        compareAll();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_state"}, int'(game_state), 0);
        checkOutput({tag, "_lives"}, int'(lives), 3);
        checkOutput({tag, "_time"}, int'(time_left), 300);
        checkOutput({tag, "_score"}, int'(score), 0);
        checkOutput({tag, "_over"}, int'(game_over), 0);
        checkOutput({tag, "_won"}, int'(level_won), 0);
    endtask

    // Asynchronous reset mid-frame, checked before any clock edge arrives.
    task automatic pulseReset();
        keycode = 8'h00;
        reset   = 1'b0;
        #2;
        checkResetValues("async_rst");
        @(posedge frame_clk);
        #1;
        reset = 1'b1;
        modelReset();
    endtask

    task automatic startToPlay(input string tag);
        int guard;
        applyStimulus(8'h28, 100, 0, 8'h00);
        guard = 0;
        do begin
            applyStimulus(8'h00, 100, 0, 8'h00);
            guard++;
        end while (game_state != 2'b01 && guard < 20);
        checkOutput({tag, "_in_play"}, int'(game_state), 1);
    endtask

    initial begin
        int         cnt10;
        int         cnt11;
        int         guard;
        int         livesBefore;
        int         timePaused;
        int         sel;
        int         y;
        int         page;
        logic [7:0] key;
        logic [7:0] flags;

        reset      = 1'b0;
        keycode    = 8'h00;
        ball_y     = 10'd0;
        page_index = 32'd0;
        blockflags = 8'h00;
        modelReset();
        repeat (3) @(posedge frame_clk);
        #1;
        checkResetValues("rst");
        reset = 1'b1;
        applyStimulus(8'h00, 100, 0, 8'h00);
        applyStimulus(8'h00, 100, 0, 8'h00);
        checkResetValues("idle");

        // Hold Enter for five frames: two RESTART frames, then PLAY.
        cnt10 = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'h28, 100, 0, 8'h00);
            if (game_state == 2'b10) cnt10++;
        end
        checkOutput("restart_frames", cnt10, 2);
        checkOutput("play_after_restart", int'(game_state), 1);

        // 120 frames of PLAY in total costs two seconds.
        for (int i = 0; i < 118; i++) applyStimulus(8'h00, 100, 0, 8'h00);
        checkOutput("timer_120", int'(time_left), 298);

        // Rising bricks score, falling ones do not.
        applyStimulus(8'h00, 100, 0, 8'h05);
        checkOutput("score_two_bricks", int'(score), 20);
        applyStimulus(8'h00, 100, 0, 8'h00);
        checkOutput("score_clear", int'(score), 20);
        applyStimulus(8'h00, 100, 0, 8'h01);
        checkOutput("score_one_brick", int'(score), 30);

        // Fall into a pit: sixty frozen frames, then a restart with one life less.
        cnt11 = 0;
        guard = 0;
        do begin
            applyStimulus(8'h00, 400, 0, 8'h00);
            if (game_state == 2'b11) cnt11++;
            guard++;
        end while (game_state != 2'b10 && guard < 200);
        checkOutput("die_frames", cnt11, 60);
        checkOutput("die_lives", int'(lives), 2);
        checkOutput("die_state", int'(game_state), 2);
        guard = 0;
        while (game_over != 1'b1 && guard < 1000) begin
            applyStimulus(8'h00, 400, 0, 8'h00);
            guard++;
        end
        checkOutput("over_flag", int'(game_over), 1);
        checkOutput("over_lives", int'(lives), 0);
        applyStimulus(8'h28, 400, 0, 8'h00);
        checkOutput("over_to_title", int'(game_state), 0);
        applyStimulus(8'h00, 100, 0, 8'h00);

        // Win and fall in the same frame: the win takes priority.
        startToPlay("win");
        applyStimulus(8'h00, 420, 3, 8'h00);
        checkOutput("win_flag", int'(level_won), 1);
        checkOutput("win_state", int'(game_state), 3);
        checkOutput("win_lives", int'(lives), 3);
        applyStimulus(8'h28, 100, 0, 8'h00);
        checkOutput("win_to_title", int'(game_state), 0);
        applyStimulus(8'h00, 100, 0, 8'h00);

        // Run the clock out, scoring random bricks (saturates the score).
        startToPlay("tmo");
        guard = 0;
        while (mTime != 0 && guard < 20000) begin
            applyStimulus(8'h00, 100, 0, 8'($urandom));
            guard++;
        end
        checkOutput("timeout_reached", int'(time_left), 0);
        livesBefore = mLives;
        applyStimulus(8'h00, 410, 0, 8'h00);
        checkOutput("timeout_dying", int'(game_state), 3);
        guard = 0;
        while (game_state == 2'b11 && guard < 100) begin
            applyStimulus(8'h00, 410, 0, 8'h00);
            guard++;
        end
        checkOutput("timeout_one_life", int'(lives), livesBefore - 1);

        // Reset in the middle of a death freeze.
        guard = 0;
        while (game_state != 2'b11 && guard < 20) begin
            applyStimulus(8'h00, 410, 0, 8'h00);
            guard++;
        end
        for (int i = 0; i < 30; i++) applyStimulus(8'h00, 410, 0, 8'h00);
        pulseReset();
        applyStimulus(8'h00, 100, 0, 8'h00);
        checkOutput("rst_dying_state", int'(game_state), 0);
        checkOutput("rst_dying_lives", int'(lives), 3);

        // Pause key behaviour.
        startToPlay("pause");
`ifdef GAME_FLOW_PAUSE_EN
        applyStimulus(8'h13, 100, 0, 8'h00);
        timePaused = mTime;
        for (int i = 0; i < 199; i++) applyStimulus(8'h13, 100, 0, 8'h01);
        checkOutput("pause_state", int'(game_state), 3);
        checkOutput("pause_time", int'(time_left), timePaused);
        applyStimulus(8'h00, 100, 0, 8'h00);
        applyStimulus(8'h13, 100, 0, 8'h00);
        checkOutput("unpause_state", int'(game_state), 1);
`else
        timePaused = mTime;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'h13, 100, 0, 8'h00);
            applyStimulus(8'h00, 100, 0, 8'h00);
        end
        checkOutput("p_ignored", int'(game_state), 1);
        checkOutput("p_time", int'(time_left), timePaused);
`endif

        // Randomised play across all states.
        for (int i = 0; i < 3000; i++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 60)      key = 8'h00;
            else if (sel < 75) key = 8'h28;
            else if (sel < 85) key = 8'h13;
            else               key = 8'($urandom);
            y    = ($urandom_range(0, 49) == 0) ? int'($urandom_range(400, 1023))
                                                : int'($urandom_range(0, 399));
            sel  = int'($urandom_range(0, 199));
            page = (sel == 0) ? int'($urandom_range(3, 9))
                              : ((sel < 10) ? -1 : int'($urandom_range(0, 2)));
            flags = ($urandom_range(0, 3) == 0) ? 8'($urandom) : mPrevFlags;
            applyStimulus(key, y, page, flags);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
